// File: rtl/coin_sequencer_if.sv
// Host-side coin request handshake for coin_sequencer.
// The host is the master. The sequencer is the slave.
interface coin_sequencer_if;
    logic coin_valid;
    logic coin_type;
    logic coin_ready;

    modport master (output coin_valid, output coin_type, input coin_ready);
    modport slave  (input coin_valid, input coin_type, output coin_ready);
endinterface

// File: rtl/coin_sequencer.sv
// Buffers host coin requests, serialises them onto the {I,J} coin lines and counts vend/change events.
// Optional shadow credit cross-check: define COIN_SEQ_SHADOW_CHECK_EN.
module coin_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 1,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    coin_sequencer_if.slave   host,
    output logic              I,
    output logic              J,
    input  logic              X,
    input  logic              Y,
    input  logic              err_clr,
    output logic              busy,
    output logic [CNT_W-1:0]  vend_count,
    output logic [CNT_W-1:0]  change_count,
    output logic [1:0]        credit,
    output logic              err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [AW:0]   FULL_OCC = FIFO_DEPTH[AW:0];
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;

    state_t        state;
    logic [GW-1:0] gap_cnt;

    logic          mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   occ;
    logic          push;
    logic          pop;

    // coin_ready comes from registered occupancy only, so a same-cycle pop never reopens a full FIFO.
    assign host.coin_ready = (occ != FULL_OCC);
    assign push = host.coin_valid && host.coin_ready;
    assign pop  = (state == IDLE) && (occ != '0);
    assign busy = (occ != '0) || (state != IDLE);

    // NOTE: FIFO storage has no reset; the pointers and occupancy define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= host.coin_type;
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   occ <= occ + (AW+1)'(1);
                2'b01:   occ <= occ - (AW+1)'(1);
                default: occ <= occ;
            endcase
        end
    end

`ifdef COIN_SEQ_SHADOW_CHECK_EN
    logic [1:0] credit_nxt;
    logic       exp_x;
    logic       exp_y;
    logic       mismatch;

    // During DRIVE, J still holds the coin type being presented to the machine.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        credit_nxt = 2'd0;
        exp_x      = 1'b0;
        exp_y      = 1'b0;
        unique case (credit)
            2'd0: credit_nxt = J ? 2'd2 : 2'd1;
            2'd1: begin
                credit_nxt = J ? 2'd0 : 2'd2;
                exp_x      = J;
            end
            2'd2: begin
                exp_x = 1'b1;
                exp_y = J;
            end
            default: credit_nxt = 2'd0;
        endcase
        mismatch = (X != exp_x) || (Y != exp_y);
    end
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign credit = 2'd0;
    assign err    = 1'b0;
`endif

    // The async reset on I/J drops the coin lines as soon as rst_n falls, even mid-pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            gap_cnt      <= '0;
            I            <= 1'b0;
            J            <= 1'b0;
            vend_count   <= '0;
            change_count <= '0;
`ifdef COIN_SEQ_SHADOW_CHECK_EN
            credit       <= 2'd0;
            err          <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (occ != '0) begin
                        state <= DRIVE;
                        I     <= 1'b1;
                        J     <= mem[rd_ptr];
                    end
                end
                DRIVE: begin
                    state   <= GAP;
                    gap_cnt <= '0;
                    I       <= 1'b0;
                    J       <= 1'b0;
                    if (X) vend_count   <= vend_count + CNT_W'(1);
                    if (Y) change_count <= change_count + CNT_W'(1);
`ifdef COIN_SEQ_SHADOW_CHECK_EN
                    credit  <= credit_nxt;
`endif
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) state <= IDLE;
                    else                     gap_cnt <= gap_cnt + GW'(1);
                end
                default: begin
                    state <= IDLE;
                    I     <= 1'b0;
                    J     <= 1'b0;
                end
            endcase
`ifdef COIN_SEQ_SHADOW_CHECK_EN
            // A mismatch takes priority over a simultaneous clear.
            if ((state == DRIVE) && mismatch) err <= 1'b1;
            else if (err_clr)                 err <= 1'b0;
`endif
        end
    end

endmodule
